// File: rtl/chrom_serial_loader_pkg.sv
// Shared widths, frame constants and loader state encoding for the chromosome load path.
package chrom_serial_loader_pkg;

    // Field widths of the 3x1 majority configuration.
    localparam int BITS_MAT   = 36;
    localparam int BITS_ELEM  = 48;
    localparam int OUT        = 1;
    localparam int BITS_MUX   = 2;

    localparam int CHROM_BITS = BITS_MAT + BITS_ELEM * OUT + BITS_MUX;
    localparam int NBYTES     = (CHROM_BITS + 7) / 8;
    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2,
        COMMIT  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/chrom_serial_loader.sv
// Rebuilds the packed chromosome from a sync / payload / XOR-check byte stream and
// commits it atomically to the active chromosome when the fabric is not holding it.
module chrom_serial_loader
    import chrom_serial_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  hold,
    output logic [CHROM_BITS-1:0] chrom,
    output logic                  chrom_valid,
    output logic                  load_done,
    output logic                  chk_err,
    output logic                  busy,
    output loader_state_t         state
);

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
    // in_ready is low only in COMMIT, so a held commit backpressures the stream.

    localparam int CNT_W = $clog2(NBYTES + 1);
    localparam int PBITS = NBYTES * 8;

    logic [CHROM_BITS-1:0] shadow;
    logic [CNT_W-1:0]      cnt;
    logic [7:0]            xr;
    logic [PBITS-1:0]      byte_pos;
    logic [PBITS-1:0]      byte_mask;
    logic                  take;

    assign take     = in_valid && in_ready;
    assign in_ready = (state != COMMIT);
    assign busy     = (state != HUNT);

    // Place the incoming byte at its lane; lanes past CHROM_BITS fall off on truncation.
    always_comb begin
        byte_pos  = PBITS'(in_data) << {cnt, 3'b000};
        byte_mask = PBITS'(8'hFF)   << {cnt, 3'b000};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            chrom       <= '0;
            shadow      <= '0;
            chrom_valid <= 1'b0;
            load_done   <= 1'b0;
            chk_err     <= 1'b0;
            cnt         <= '0;
            xr          <= '0;
        end else begin
            load_done <= 1'b0;
            chk_err   <= 1'b0;
            case (state)
                HUNT: begin
                    if (take && in_data == SYNC) begin
                        state <= PAYLOAD;
                        cnt   <= '0;
                        xr    <= '0;
                    end
                end
                PAYLOAD: begin
                    if (take) begin
                        shadow <= (shadow & ~byte_mask[CHROM_BITS-1:0]) | byte_pos[CHROM_BITS-1:0];
                        xr     <= xr ^ in_data;
                        cnt    <= cnt + 1'b1;
                        if (cnt == CNT_W'(NBYTES - 1)) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (take) begin
                        if (in_data == xr) begin
                            state <= COMMIT;
                        end else begin
                            chk_err <= 1'b1;
                            state   <= HUNT;
                        end
                    end
                end
                COMMIT: begin
                    if (!hold) begin
                        chrom       <= shadow;
                        chrom_valid <= 1'b1;
                        load_done   <= 1'b1;
                        state       <= HUNT;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_chrom_serial_loader.sv
// Directed and randomized frames for chrom_serial_loader against a byte-level frame model.
module tb_chrom_serial_loader;
    import chrom_serial_loader_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  hold;
    logic [CHROM_BITS-1:0] chrom;
    logic                  chrom_valid;
    logic                  load_done;
    logic                  chk_err;
    logic                  busy;
    loader_state_t         state;

    int total = 0;
    int bad   = 0;

    logic [7:0]            pay [NBYTES];
    logic [CHROM_BITS-1:0] exp_chrom;
    logic                  exp_valid;
    logic [CHROM_BITS-1:0] maj_chrom;

    chrom_serial_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .hold        (hold),
        .chrom       (chrom),
        .chrom_valid (chrom_valid),
        .load_done   (load_done),
        .chk_err     (chk_err),
        .busy        (busy),
        .state       (state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one byte and returns 1ns after the edge that transferred it.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end
        end
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("ready_timeout", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Frame model: payload bytes laid LSB-first, truncated to the chromosome width;
    // check byte is the XOR of all payload bytes including discarded upper bits.
    task automatic run_frame(input bit corrupt, input int hold_cyc, input bit gaps);
        logic [NBYTES*8-1:0]   full;
        logic [7:0]            x;
        logic [CHROM_BITS-1:0] prev;
        logic                  prev_valid;
        full = '0;
        x    = 8'h00;
        for (int k = 0; k < NBYTES; k++) begin
            full[8*k +: 8] = pay[k];
            x = x ^ pay[k];
        end
        if (corrupt) x = x ^ 8'h01;
        prev       = exp_chrom;
        prev_valid = exp_valid;

        send_byte(SYNC, gaps);
        for (int k = 0; k < NBYTES; k++) send_byte(pay[k], gaps);
        check("busy_before_check", 128'(busy), 128'(1));
        check("chrom_midframe", 128'(chrom), 128'(prev));
        hold = (hold_cyc > 0);
        send_byte(x, gaps);

        if (corrupt) begin
            check("chk_err_pulse", 128'(chk_err), 128'(1));
            check("no_done_on_bad", 128'(load_done), 128'(0));
            check("chrom_kept_bad", 128'(chrom), 128'(prev));
            check("valid_kept_bad", 128'(chrom_valid), 128'(prev_valid));
            check("idle_after_bad", 128'(busy), 128'(0));
            @(posedge clk);
            #1;
            check("chk_err_once", 128'(chk_err), 128'(0));
            hold = 1'b0;
        end else begin
            for (int i = 0; i < hold_cyc; i++) begin
                check("hold_ready_low", 128'(in_ready), 128'(0));
                check("hold_chrom_kept", 128'(chrom), 128'(prev));
                check("hold_no_done", 128'(load_done), 128'(0));
                @(posedge clk);
                #1;
            end
            hold = 1'b0;
            check("chrom_before_commit", 128'(chrom), 128'(prev));
            exp_chrom = full[CHROM_BITS-1:0];
            exp_valid = 1'b1;
            @(posedge clk);
            #1;
            check("chrom_committed", 128'(chrom), 128'(exp_chrom));
            check("load_done_pulse", 128'(load_done), 128'(1));
            check("no_err_on_good", 128'(chk_err), 128'(0));
            check("chrom_valid_set", 128'(chrom_valid), 128'(1));
            check("idle_after_commit", 128'(busy), 128'(0));
            @(posedge clk);
            #1;
            check("load_done_once", 128'(load_done), 128'(0));
        end
    endtask

    task automatic load_maj();
        logic [NBYTES*8-1:0] t;
        t = (NBYTES*8)'(maj_chrom);
        for (int k = 0; k < NBYTES; k++) pay[k] = t[8*k +: 8];
    endtask

    initial begin
        maj_chrom = CHROM_BITS'(80'h2A5C3F0F1E96A533CCE1);
        exp_chrom = '0;
        exp_valid = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        hold      = 1'b0;
        rst_n     = 1'b0;
        #12;
        check("rst_chrom", 128'(chrom), 128'(0));
        check("rst_valid", 128'(chrom_valid), 128'(0));
        check("rst_done", 128'(load_done), 128'(0));
        check("rst_err", 128'(chk_err), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Bad check byte right after reset: nothing may commit.
        load_maj();
        run_frame(1'b1, 0, 1'b0);

        // Good majority chromosome.
        load_maj();
        run_frame(1'b0, 0, 1'b0);
        check("maj_value", 128'(chrom), 128'(maj_chrom));

        // Hold backpressure for 20 cycles.
        for (int k = 0; k < NBYTES; k++) pay[k] = 8'(k * 17 + 3);
        run_frame(1'b0, 20, 1'b0);

        // Garbage before sync, and sync values inside the payload.
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h3C, 1'b0);
        check("garbage_ignored", 128'(busy), 128'(0));
        for (int k = 0; k < NBYTES; k++) pay[k] = (k % 3 == 0) ? SYNC : 8'(k);
        run_frame(1'b0, 0, 1'b0);

        // Reset mid-frame, then a full good frame.
        send_byte(SYNC, 1'b0);
        for (int k = 0; k < 5; k++) send_byte(8'h5A, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_chrom", 128'(chrom), 128'(0));
        check("midrst_valid", 128'(chrom_valid), 128'(0));
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_done", 128'(load_done), 128'(0));
        @(negedge clk);
        rst_n     = 1'b1;
        exp_chrom = '0;
        exp_valid = 1'b0;
        for (int k = 0; k < NBYTES; k++) pay[k] = 8'($urandom);
        run_frame(1'b0, 0, 1'b0);

        // Upper-bit discard on the last byte.
        for (int k = 0; k < NBYTES; k++) pay[k] = 8'($urandom);
        pay[NBYTES-1] = 8'hFF;
        run_frame(1'b0, 0, 1'b0);
        check("upper_bits", 128'(chrom[CHROM_BITS-1 -: 6]), 128'(6'h3F));

        // Randomized frames with idle gaps, random holds and random corruption.
        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < NBYTES; k++) pay[k] = 8'($urandom);
            run_frame($urandom_range(0, 3) == 0, $urandom_range(0, 4), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chrom_serial_loader.md
Name: chrom_serial_loader

Overview:
- Receiver side of the chromosome load path: takes a byte stream from the serial front end and rebuilds the packed chromosome that drives the genetic evaluation fabric.
- A frame is one sync byte, then the payload bytes, then one XOR check byte.
- Payload bytes fill a shadow register. On a good check, the shadow is copied atomically to the active chromosome, but only while the fabric is not holding the configuration.
- The active chromosome never changes mid-frame or on a bad frame.

Parameters:
- CHROM_BITS, 86: chromosome width, equal to BITS_MAT + BITS_ELEM*OUT + BITS_MUX (36 + 50 for the 3x1 majority configuration).
- NBYTES, (CHROM_BITS+7)/8 = 11: payload bytes per frame.
- SYNC, 8'hA5: frame start byte.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  8  received byte
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  loader accepts in_data; transfer happens when in_valid && in_ready
- hold  input  1  fabric is mid-evaluation; blocks the commit
- chrom  output  CHROM_BITS  active chromosome, LSB = cromossomo[0]
- chrom_valid  output  1  at least one good frame has been committed since reset
- load_done  output  1  one-cycle pulse on commit
- chk_err  output  1  one-cycle pulse on a check-byte mismatch
- busy  output  1  state != HUNT

Behaviour:
- Reset (async, rst_n low):
  - state=HUNT, chrom=0, shadow=0, chrom_valid=0, load_done=0, chk_err=0, byte counter=0, running XOR=0.
  - Reset mid-frame discards the partial frame; chrom returns to 0.
- States: HUNT, PAYLOAD, CHECK, COMMIT.
- HUNT:
  - in_ready=1.
  - Accepted byte == SYNC: go to PAYLOAD; clear counter and XOR.
  - Any other byte is dropped silently.
- PAYLOAD:
  - in_ready=1.
  - Payload byte k (k = 0..NBYTES-1) is written to shadow[8k +: 8]; bits at or above CHROM_BITS are discarded.
  - Each byte is XORed into the running XOR.
  - After byte NBYTES-1 is accepted: go to CHECK.
  - A SYNC value inside the payload is ordinary data (no resync).
- CHECK:
  - in_ready=1.
  - Accepted byte == running XOR: go to COMMIT.
  - Otherwise: chk_err=1 for the next cycle, go to HUNT, chrom unchanged.
- COMMIT:
  - in_ready=0.
  - When hold=0: chrom <= shadow, chrom_valid <= 1, load_done=1 for one cycle, go to HUNT.
  - When hold=1: wait indefinitely; bytes are not accepted (backpressure).
- Latency: chrom updates on the clock edge after entering COMMIT with hold=0, so 1 cycle after the check byte is accepted when hold=0.
- load_done and chk_err are registered and never both high.
- in_valid low in any state: no state change.
- Byte counter width is $clog2(NBYTES+1); it never wraps within a frame.
- The checksum covers the discarded upper bits of the last byte.

Decomposition:
- Shared parameters package holds:
  - CHROM_BITS, computed from BITS_MAT, BITS_ELEM, OUT, BITS_MUX;
  - NBYTES and SYNC;
  - the state enum loader_state_t {HUNT, PAYLOAD, CHECK, COMMIT}.
- No sub-module is needed: shadow, counter, XOR and FSM sit in one block.
- The top level replaces its constant chromosome with chrom from this block and gates evaluation with chrom_valid.

Test Plan:
- Good frame, majority chromosome:
  - Stimulus: A5, the 11 bytes of the 86-bit 3x1 majority chromosome LSB-first, correct XOR, hold=0.
  - Response: chrom equals that chromosome 1 cycle after the check byte; one load_done pulse; chrom_valid=1.
- Bad check byte:
  - Stimulus: same frame with the check byte XOR 0x01.
  - Response: one chk_err pulse, chrom unchanged (0 after reset), chrom_valid stays 0, state back to HUNT.
- Hold backpressure:
  - Stimulus: good frame with hold=1 for 20 cycles.
  - Response: in_ready=0 and chrom unchanged for all 20 cycles; commit and load_done on the first cycle after hold drops.
- Garbage and in-payload sync:
  - Stimulus: bytes 00 FF 3C, then A5, then a payload containing A5 bytes, then a correct check byte.
  - Response: leading bytes ignored; frame commits correctly with the A5 bytes taken as data.
- Reset mid-frame:
  - Stimulus: rst_n pulsed low after 5 payload bytes, then a complete good frame.
  - Response: all outputs 0 during reset; no commit from the partial frame; the second frame commits normally.
- Upper-bit discard:
  - Stimulus: good frame whose last byte is FF with a correct check byte.
  - Response: chrom[85:80]=6'h3F; bits 86-87 are not stored and the frame passes the check.
